pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 12 +
 rtl/pipelined_adder_if.sv | 26 ++
 rtl/pipelined_adder_stage.sv | 57 +++++
 rtl/pipelined_adder.sv | 73 +++++++
 tb/tb_pipelined_adder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and parameter sanity check for the pipelined adder.
package pipelined_adder_pkg;

    localparam int ADDER_HALF = 0;
    localparam int ADDER_FULL = 1;

    function automatic bit adder_params_ok(input int width, input int stages, input int adder_type);
        return (width >= 2) && (stages >= 1) && (stages <= width) && (width % stages == 0) &&
               ((adder_type == ADDER_HALF) || (adder_type == ADDER_FULL));
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/pipelined_adder_stage.sv
// One registered slice: adds SEG bits, registers the carry and forwards the
// remaining operand bits plus the sum bits produced so far.
module adder_stage #(
    parameter int unsigned SEG = 4,
    parameter int unsigned LOW = 0,
    parameter int unsigned REM = 8,
    localparam int unsigned IW = LOW + 2 * REM,
    localparam int unsigned OW = IW - SEG
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid_i,
    input  logic          ready_i,
    input  logic          c_i,
    input  logic [IW-1:0] x_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic          c_o,
    output logic [OW-1:0] y_o
);

    logic          v_q;
    logic          c_q, c_d;
    logic [OW-1:0] y_q, y_d;
    logic [SEG:0]  t;

    // Payload layout: {b_rem, a_rem, sum_low}; the slice is the bottom SEG bits of each remainder.
    always_comb begin
        t = {1'b0, x_i[LOW +: SEG]} + {1'b0, x_i[LOW + REM +: SEG]} + (SEG + 1)'(c_i);
        c_d = t[SEG];
        y_d = '0;
        for (int unsigned i = 0; i < LOW; i++) y_d[i] = x_i[i];
        y_d[LOW +: SEG] = t[SEG-1:0];
        for (int unsigned i = LOW + SEG; i < LOW + REM; i++) y_d[i] = x_i[i];
        for (int unsigned i = LOW + REM; i < OW; i++) y_d[i] = x_i[i + SEG];
    end

    assign ready_o = !v_q || ready_i;
    assign valid_o = v_q;
    assign c_o     = c_q;
    assign y_o     = y_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            y_q <= '0;
        end else if (ready_o) begin
            v_q <= valid_i;
            if (valid_i) begin
                c_q <= c_d;
                y_q <= y_d;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Ripple-carry adder split into STAGES registered slices with valid/ready flow control.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STAGES     = 2,
    parameter int ADDER_TYPE = ADDER_FULL
) (
    input logic               clk,
    input logic               rstn,
    pipelined_adder_if.slave  bus
);

    localparam int unsigned SEG = WIDTH / STAGES;

    if (!adder_params_ok(WIDTH, STAGES, ADDER_TYPE)) begin : g_bad_params
        $error("pipelined_adder: illegal WIDTH/STAGES/ADDER_TYPE combination");
    end

    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [STAGES:0] cy;

    case (ADDER_TYPE)
        ADDER_FULL: begin : g_full
            assign cy[0] = bus.cin;
        end
        default: begin : g_half
            assign cy[0] = 1'b0;
        end
    endcase

    assign vld[0]       = bus.in_valid;
    assign rdy[STAGES]  = bus.out_ready;
    assign bus.in_ready = rdy[0];

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LOW = k * SEG;
        localparam int unsigned REM = WIDTH - k * SEG;

        logic [LOW+2*REM-1:0]     x;
        logic [LOW+2*REM-SEG-1:0] y;

        if (k == 0) begin : g_first
            assign x = {bus.b, bus.a};
        end else begin : g_next
            assign x = g_stage[k-1].y;
        end

        adder_stage #(
            .SEG (SEG),
            .LOW (LOW),
            .REM (REM)
        ) u_stage (
            .clk     (clk),
            .rstn    (rstn),
            .valid_i (vld[k]),
            .ready_i (rdy[k+1]),
            .c_i     (cy[k]),
            .x_i     (x),
            .ready_o (rdy[k]),
            .valid_o (vld[k+1]),
            .c_o     (cy[k+1]),
            .y_o     (y)
        );
    end

    assign bus.out_valid = vld[STAGES];
    assign bus.cout      = cy[STAGES];
    assign bus.sum       = g_stage[STAGES-1].y;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks of pipelined_adder across four parameter sets.
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       iv8, or8, cin8;
    logic [7:0] a8, b8;

    pipelined_adder_if #(.WIDTH(8))  if_f ();
    pipelined_adder_if #(.WIDTH(8))  if_h ();
    pipelined_adder_if #(.WIDTH(8))  if_s1 ();
    pipelined_adder_if #(.WIDTH(16)) if_w ();

    assign {if_f.in_valid, if_f.out_ready, if_f.cin, if_f.a, if_f.b}     = {iv8, or8, cin8, a8, b8};
    assign {if_h.in_valid, if_h.out_ready, if_h.cin, if_h.a, if_h.b}     = {iv8, or8, cin8, a8, b8};
    assign {if_s1.in_valid, if_s1.out_ready, if_s1.cin, if_s1.a, if_s1.b} = {iv8, or8, cin8, a8, b8};

    pipelined_adder #(.WIDTH(8), .STAGES(2), .ADDER_TYPE(ADDER_FULL)) u_f (
        .clk(clk), .rstn(rstn), .bus(if_f));
    pipelined_adder #(.WIDTH(8), .STAGES(2), .ADDER_TYPE(ADDER_HALF)) u_h (
        .clk(clk), .rstn(rstn), .bus(if_h));
    pipelined_adder #(.WIDTH(8), .STAGES(1), .ADDER_TYPE(ADDER_FULL)) u_s1 (
        .clk(clk), .rstn(rstn), .bus(if_s1));
    pipelined_adder #(.WIDTH(16), .STAGES(4), .ADDER_TYPE(ADDER_FULL)) u_w (
        .clk(clk), .rstn(rstn), .bus(if_w));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        iv8  = v;
        a8   = a;
        b8   = b;
        cin8 = c;
    endtask

    logic [16:0] q[$];
    logic [16:0] exp_w;
    int          acc, got, cyc;

    initial begin
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        or8 = 1'b1;
        if_w.in_valid = 1'b0; if_w.out_ready = 1'b1;
        if_w.a = '0; if_w.b = '0; if_w.cin = 1'b0;
        rstn = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(if_f.out_valid), 0);
        check("rst_sum",   32'(if_f.sum), 0);
        check("rst_cout",  32'(if_f.cout), 0);
        check("rst_ready", 32'(if_f.in_ready), 1);
        check("rst_w_valid", 32'(if_w.out_valid), 0);

        // FF + 01: wraps to 00 with carry, two-cycle latency
        rstn = 1'b1;
        drive(1'b1, 8'hFF, 8'h01, 1'b0);
        #1 check("a_in_ready", 32'(if_f.in_ready), 1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("a_lat1_valid", 32'(if_f.out_valid), 0);
        tick();
        check("a_valid", 32'(if_f.out_valid), 1);
        check("a_sum",   32'(if_f.sum), 32'h00);
        check("a_cout",  32'(if_f.cout), 1);
        tick();
        check("a_drained", 32'(if_f.out_valid), 0);

        // 03 + 04 + cin=1: half mode ignores cin
        drive(1'b1, 8'h03, 8'h04, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("b_s1_valid", 32'(if_s1.out_valid), 1);
        check("b_s1_sum",   32'(if_s1.sum), 32'h08);
        tick();
        check("b_h_valid", 32'(if_h.out_valid), 1);
        check("b_h_sum",   32'(if_h.sum), 32'h07);
        check("b_h_cout",  32'(if_h.cout), 0);
        check("b_f_sum",   32'(if_f.sum), 32'h08);
        tick();

        // 80 + 80 + 1 at single-stage latency
        drive(1'b1, 8'h80, 8'h80, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("c_s1_valid", 32'(if_s1.out_valid), 1);
        check("c_s1_sum",   32'(if_s1.sum), 32'h01);
        check("c_s1_cout",  32'(if_s1.cout), 1);
        tick();
        check("c_f_sum",  32'(if_f.sum), 32'h01);
        check("c_f_cout", 32'(if_f.cout), 1);
        tick();

        // Backpressure: two accepted, third stalls until out_ready rises
        or8 = 1'b0;
        drive(1'b1, 8'h10, 8'h20, 1'b0);
        #1 check("d_ready0", 32'(if_f.in_ready), 1);
        tick();
        drive(1'b1, 8'hF0, 8'h20, 1'b1);
        #1 check("d_ready1", 32'(if_f.in_ready), 1);
        tick();
        drive(1'b1, 8'h7F, 8'h01, 1'b0);
        #1 check("d_full_ready", 32'(if_f.in_ready), 0);
        check("d_hold_valid", 32'(if_f.out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("d_stable_sum",   32'(if_f.sum), 32'h30);
            check("d_stable_cout",  32'(if_f.cout), 0);
            check("d_stable_ready", 32'(if_f.in_ready), 0);
        end
        or8 = 1'b1;
        #1 check("d_o0_sum", 32'(if_f.sum), 32'h30);
        check("d_release_ready", 32'(if_f.in_ready), 1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("d_o1_sum",  32'(if_f.sum), 32'h11);
        check("d_o1_cout", 32'(if_f.cout), 1);
        tick();
        check("d_o2_valid", 32'(if_f.out_valid), 1);
        check("d_o2_sum",   32'(if_f.sum), 32'h80);
        check("d_o2_cout",  32'(if_f.cout), 0);
        tick();
        check("d_empty", 32'(if_f.out_valid), 0);

        // Reset with two transactions in flight
        or8 = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        tick();
        drive(1'b1, 8'h33, 8'h44, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("e_inflight", 32'(if_f.out_valid), 1);
        rstn = 1'b0;
        tick();
        check("e_valid", 32'(if_f.out_valid), 0);
        check("e_sum",   32'(if_f.sum), 0);
        check("e_cout",  32'(if_f.cout), 0);
        check("e_ready", 32'(if_f.in_ready), 1);
        rstn = 1'b1;
        or8  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("e_no_stale", 32'(if_f.out_valid), 0);
        end

        // Random traffic on the 16-bit, 4-stage instance
        acc = 0; got = 0; cyc = 0;
        while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
            if_w.in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
            if_w.a         = 16'($urandom);
            if_w.b         = 16'($urandom);
            if_w.cin       = 1'($urandom_range(0, 1));
            if_w.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (if_w.in_valid && if_w.in_ready) begin
                q.push_back({1'b0, if_w.a} + {1'b0, if_w.b} + 17'(if_w.cin));
                acc++;
            end
            if (if_w.out_valid && if_w.out_ready) begin
                if (q.size() > 0) begin
                    exp_w = q.pop_front();
                    check("w_result", 32'({if_w.cout, if_w.sum}), 32'(exp_w));
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if_w.in_valid = 1'b0;
        check("w_accepted", 32'(acc), 1000);
        check("w_count",    32'(got), 1000);
        check("w_drained",  32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
